dec10to8_rx: RTL and testbench

Receive-side stage directly downstream of the 8b/10b framing encoder. It decodes 10-bit symbols back to 9-bit {K,byte} and tracks running disparity. It flags code and disparity violations. It also recovers packet framing (K28.1 preamble, payload, K23.7, 4 CRC bytes, K28.5) and checks CRC-32 over the payload.

---
 rtl/dec10to8_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_dec10to8_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dec10to8_rx.sv
// dec10to8_rx: 8b/10b symbol decoder with running-disparity tracking,
// packet framing recovery (K28.1 preamble .. K23.7 + CRC .. K28.5) and CRC-32 check.
module dec10to8_rx #(
    parameter int          MIN_PRE  = 1,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pushin,
    input  logic [9:0] datain,
    output logic       pushout,
    output logic [8:0] dataout,
    output logic       startout,
    output logic       endout,
    output logic       crcok,
    output logic       codeerr,
    output logic       disperr
);
    typedef enum logic [2:0] {HUNT, PRE, DATA, CRCB, TAIL} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    state_t      r_state, w_state;
    logic        r_rd;
    logic [31:0] r_crc, w_crc, r_rx, w_rx;
    logic [3:0]  r_cnt, w_cnt;
    logic [1:0]  r_idx, w_idx;
    logic        w_push, w_start, w_end, w_ok;
    logic [5:0]  w_s6;
    logic [3:0]  w_s4, w_t4;
    logic [4:0]  w_x;
    logic [2:0]  w_y, w_n6, w_n4;
    logic        w_v6, w_v4, w_k28, w_kx7, w_k, w_valid;
    logic        w_rd6, w_rd4, w_derr, w_k281, w_k237, w_k285;
    logic [7:0]  w_byte;

    // sub-blocks are held with the first-transmitted bit as MSB to match code tables
    assign w_s6    = {datain[0], datain[1], datain[2], datain[3], datain[4], datain[5]};
    assign w_s4    = {datain[6], datain[7], datain[8], datain[9]};
    assign w_k28   = (w_s6 == 6'b001111) || (w_s6 == 6'b110000);
    assign w_t4    = (w_s6 == 6'b110000) ? ~w_s4 : w_s4;
    assign w_n6    = 3'($countones(w_s6));
    assign w_n4    = 3'($countones(w_s4));

    always_comb begin
        w_v6 = 1'b1;
        w_x  = 5'd0;
        case (w_s6)
            6'b100111, 6'b011000: w_x = 5'd0;
            6'b011101, 6'b100010: w_x = 5'd1;
            6'b101101, 6'b010010: w_x = 5'd2;
            6'b110001:            w_x = 5'd3;
            6'b110101, 6'b001010: w_x = 5'd4;
            6'b101001:            w_x = 5'd5;
            6'b011001:            w_x = 5'd6;
            6'b111000, 6'b000111: w_x = 5'd7;
            6'b111001, 6'b000110: w_x = 5'd8;
            6'b100101:            w_x = 5'd9;
            6'b010101:            w_x = 5'd10;
            6'b110100:            w_x = 5'd11;
            6'b001101:            w_x = 5'd12;
            6'b101100:            w_x = 5'd13;
            6'b011100:            w_x = 5'd14;
            6'b010111, 6'b101000: w_x = 5'd15;
            6'b011011, 6'b100100: w_x = 5'd16;
            6'b100011:            w_x = 5'd17;
            6'b010011:            w_x = 5'd18;
            6'b110010:            w_x = 5'd19;
            6'b001011:            w_x = 5'd20;
            6'b101010:            w_x = 5'd21;
            6'b011010:            w_x = 5'd22;
            6'b111010, 6'b000101: w_x = 5'd23;
            6'b110011, 6'b001100: w_x = 5'd24;
            6'b100110:            w_x = 5'd25;
            6'b010110:            w_x = 5'd26;
            6'b110110, 6'b001001: w_x = 5'd27;
            6'b001110:            w_x = 5'd28;
            6'b101110, 6'b010001: w_x = 5'd29;
            6'b011110, 6'b100001: w_x = 5'd30;
            6'b101011, 6'b010100: w_x = 5'd31;
            6'b001111, 6'b110000: w_x = 5'd28;
            default:              w_v6 = 1'b0;
        endcase
    end

    // K28 4b codes are matched after folding the RD+ form onto the RD- form
    always_comb begin
        w_v4 = 1'b1;
        w_y  = 3'd0;
        if (w_k28)
            case (w_t4)
                4'b0100: w_y = 3'd0;
                4'b1001: w_y = 3'd1;
                4'b0101: w_y = 3'd2;
                4'b0011: w_y = 3'd3;
                4'b0010: w_y = 3'd4;
                4'b1010: w_y = 3'd5;
                4'b0110: w_y = 3'd6;
                4'b1000: w_y = 3'd7;
                default: w_v4 = 1'b0;
            endcase
        else
            case (w_s4)
                4'b1011, 4'b0100:                   w_y = 3'd0;
                4'b1001:                            w_y = 3'd1;
                4'b0101:                            w_y = 3'd2;
                4'b1100, 4'b0011:                   w_y = 3'd3;
                4'b1101, 4'b0010:                   w_y = 3'd4;
                4'b1010:                            w_y = 3'd5;
                4'b0110:                            w_y = 3'd6;
                4'b1110, 4'b0001, 4'b0111, 4'b1000: w_y = 3'd7;
                default:                            w_v4 = 1'b0;
            endcase
    end

    assign w_kx7   = !w_k28 && (w_x == 5'd23 || w_x == 5'd27 || w_x == 5'd29 || w_x == 5'd30)
                     && (w_s4 == 4'b0111 || w_s4 == 4'b1000);
    assign w_k     = w_k28 | w_kx7;
    assign w_valid = w_v6 & w_v4;
    assign w_byte  = {w_y, w_x};
    assign w_k281  = w_k && w_byte == 8'h3C;
    assign w_k237  = w_k && w_byte == 8'hF7;
    assign w_k285  = w_k && w_byte == 8'hBC;
    assign w_rd6   = (w_n6 == 3'd4) ? 1'b1 : (w_n6 == 3'd2) ? 1'b0 :
                     (w_s6 == 6'b000111) ? 1'b1 : (w_s6 == 6'b111000) ? 1'b0 : r_rd;
    assign w_rd4   = (w_n4 == 3'd3) ? 1'b1 : (w_n4 == 3'd1) ? 1'b0 :
                     (w_s4 == 4'b0011) ? 1'b1 : (w_s4 == 4'b1100) ? 1'b0 : w_rd6;
    assign w_derr  = (w_n6 == 3'd4 && r_rd) || (w_n6 == 3'd2 && !r_rd) ||
                     (w_n4 == 3'd3 && w_rd6) || (w_n4 == 3'd1 && !w_rd6);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_rx    = r_rx;
        w_crc   = r_crc;
        w_push  = 1'b0;
        w_start = 1'b0;
        w_end   = 1'b0;
        w_ok    = 1'b0;
        if (pushin) begin
            if (!w_valid) w_state = HUNT;
            else
                case (r_state)
                    HUNT: if (w_k281) begin
                        w_state = PRE;
                        w_cnt   = 4'd1;
                    end
                    PRE: if (w_k281) w_cnt = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
                    else if (r_cnt >= 4'(MIN_PRE) && (!w_k || w_k237)) begin
                        w_state = w_k ? CRCB : DATA;
                        w_idx   = 2'd0;
                        w_push  = !w_k;
                        w_start = !w_k;
                        w_crc   = w_k ? CRC_INIT : crc_byte(CRC_INIT, w_byte);
                    end else w_state = HUNT;
                    DATA: if (w_k281) begin
                        w_state = PRE;
                        w_cnt   = 4'd1;
                    end else if (w_k285) w_state = HUNT;
                    else if (w_k237) begin
                        w_state = CRCB;
                        w_idx   = 2'd0;
                    end else begin
                        w_push = 1'b1;
                        w_crc  = crc_byte(r_crc, w_byte);
                    end
                    CRCB: if (w_k) w_state = HUNT;
                    else begin
                        w_rx[{r_idx, 3'b000} +: 8] = w_byte;
                        w_idx   = r_idx + 2'd1;
                        w_state = (r_idx == 2'd3) ? TAIL : CRCB;
                    end
                    TAIL: begin
                        w_state = HUNT;
                        w_end   = w_k285;
                        w_ok    = w_k285 && (r_rx == ~r_crc);
                    end
                    default: w_state = HUNT;
                endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_rd     <= 1'b0;
            r_crc    <= CRC_INIT;
            r_cnt    <= 4'd0;
            r_idx    <= 2'd0;
            r_rx     <= 32'd0;
            pushout  <= 1'b0;
            dataout  <= 9'd0;
            startout <= 1'b0;
            endout   <= 1'b0;
            crcok    <= 1'b0;
            codeerr  <= 1'b0;
            disperr  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rd     <= (pushin && w_valid) ? w_rd4 : r_rd;
            r_crc    <= w_crc;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_rx     <= w_rx;
            pushout  <= w_push;
            dataout  <= w_push ? {w_k, w_byte} : dataout;
            startout <= w_start;
            endout   <= w_end;
            crcok    <= w_ok;
            codeerr  <= pushin & ~w_valid;
            disperr  <= pushin & w_derr;
        end
    end
endmodule

// File: tb/tb_dec10to8_rx.sv
// tb_dec10to8_rx: table-driven bench for dec10to8_rx; symbols and expected outputs are hand-derived.
module tb_dec10to8_rx;
    logic       clk = 1'b0, reset = 1'b1, pushin = 1'b0;
    logic [9:0] datain = 10'd0;
    logic       pushout, startout, endout, crcok, codeerr, disperr;
    logic [8:0] dataout;

    dec10to8_rx #(.MIN_PRE(3)) dut (
        .clk(clk), .reset(reset), .pushin(pushin), .datain(datain),
        .pushout(pushout), .dataout(dataout), .startout(startout), .endout(endout),
        .crcok(crcok), .codeerr(codeerr), .disperr(disperr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  din;
        logic [14:0] exp;
    } vec_t;

    // expected tuple: {pushout, dataout, startout, endout, crcok, codeerr, disperr}
    localparam logic [14:0] Z       = 15'd0;
    localparam logic [14:0] PS0     = {1'b1, 9'h000, 5'b10000};
    localparam logic [14:0] PS0D    = {1'b1, 9'h000, 5'b10001};
    localparam logic [14:0] PS1     = {1'b1, 9'h001, 5'b10000};
    localparam logic [14:0] END_OK  = {1'b0, 9'h000, 5'b01100};
    localparam logic [14:0] END_BAD = {1'b0, 9'h000, 5'b01000};
    localparam logic [14:0] CE      = {1'b0, 9'h000, 5'b00010};
    localparam logic [14:0] CD      = {1'b0, 9'h000, 5'b00011};

    vec_t q[$];
    int   checks = 0, errors = 0;
    logic [9:0] k281n, k281p, k285p, k237n, k237p, d00n, d00p, d134, d124, d157, d020, d186,
                d10n, d10p, bad1, bad2;

    function automatic logic [9:0] sym(input logic [5:0] s6, input logic [3:0] s4);
        logic [9:0] v, r;
        v = {s6, s4};
        for (int i = 0; i < 10; i++) r[i] = v[9 - i];
        return r;
    endfunction

    function automatic logic [14:0] outs_m();
        return {pushout, pushout ? dataout : 9'd0, startout, endout, crcok, codeerr, disperr};
    endfunction

    function automatic logic [14:0] outs_raw();
        return {pushout, dataout, startout, endout, crcok, codeerr, disperr};
    endfunction

    task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] d, input logic p);
        @(negedge clk);
        datain = d;
        pushin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [9:0] d, input logic [14:0] e);
        q.push_back('{d, e});
    endtask

    task automatic play(input string nm, input bit gap);
        foreach (q[i]) begin
            step(q[i].din, 1'b1);
            chk($sformatf("%s[%0d]", nm, i), outs_m(), q[i].exp);
            if (gap) begin
                step(10'd0, 1'b0);
                chk($sformatf("%s_gap[%0d]", nm, i), outs_m(), Z);
            end
        end
        q.delete();
    endtask

    task automatic pre4();
        add(k281n, Z); add(k281p, Z); add(k281n, Z); add(k281p, Z);
    endtask

    // first n symbols of the clean single-byte packet (payload 00, CRC D202EF8D)
    task automatic add_a(input int n, input logic [9:0] crc0, input logic [14:0] last);
        vec_t a[11];
        a = '{'{k281n, Z}, '{k281p, Z}, '{k281n, Z}, '{k281p, Z}, '{d00n, PS0}, '{k237n, Z},
              '{crc0, Z}, '{d157, Z}, '{d020, Z}, '{d186, Z}, '{k285p, last}};
        for (int i = 0; i < n; i++) q.push_back(a[i]);
    endtask

    initial begin
        k281n = sym(6'b001111, 4'b1001);
        k281p = sym(6'b110000, 4'b0110);
        k285p = sym(6'b110000, 4'b0101);
        k237n = sym(6'b111010, 4'b1000);
        k237p = sym(6'b000101, 4'b0111);
        d00n  = sym(6'b100111, 4'b0100);
        d00p  = sym(6'b011000, 4'b1011);
        d134  = sym(6'b101100, 4'b1101);
        d124  = sym(6'b001101, 4'b1101);
        d157  = sym(6'b101000, 4'b1110);
        d020  = sym(6'b010010, 4'b1011);
        d186  = sym(6'b010011, 4'b0110);
        d10n  = sym(6'b011101, 4'b0100);
        d10p  = sym(6'b100010, 4'b1011);
        bad1  = sym(6'b111111, 4'b1001);
        bad2  = sym(6'b111111, 4'b0100);

        repeat (2) @(posedge clk);
        #1 chk("reset", outs_raw(), Z);
        @(negedge clk) reset = 1'b0;

        add_a(11, d134, END_OK);  play("clean", 1'b0);
        add_a(11, d124, END_BAD); play("badcrc", 1'b0);
        add_a(11, d134, END_OK);  play("gaps", 1'b1);

        pre4(); add(d00n, PS0); add(bad1, CE); add(k237n, Z); add(d134, Z); add(d157, Z);
        add(d020, Z); add(d186, Z); add(k285p, Z); add(bad2, CD);
        play("codeerr", 1'b0);

        pre4(); add(d00p, PS0D); add(k285p, Z);
        play("disperr", 1'b0);

        add(k281n, Z); add(k281p, Z); add(d10n, Z);
        add(k281n, Z); add(k281p, Z); add(k281n, Z); add(d10p, PS1); add(k285p, Z);
        play("minpre", 1'b0);

        add(k281n, Z); add(k281p, Z); add(k281n, Z); add(k237p, Z);
        repeat (4) add(d00p, Z);
        add(k285p, END_OK);
        play("empty", 1'b0);

        add_a(5, d134, END_OK); play("pre_rst", 1'b0);
        #2 reset = 1'b1;
        #1 chk("rst_async", outs_raw(), Z);
        @(negedge clk) reset = 1'b0;
        pushin = 1'b0;

        add_a(8, d134, END_OK); play("crcb", 1'b0);
        #2 reset = 1'b1;
        pushin = 1'b0;
        #1 chk("rst_crcb", outs_raw(), Z);
        @(negedge clk) reset = 1'b0;
        add_a(11, d134, END_OK); play("after_rst", 1'b0);

        step(10'd0, 1'b0); chk("idle0", outs_m(), Z);
        step(d00n, 1'b0);  chk("idle1", outs_m(), Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
